// File: rtl/fp_divider_if.sv
// Operand/result bundle for the 8-bit floating-point divider.
// start is sampled only while the divider is idle; done pulses once and q/flags are valid with it.
interface fp_divider_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic       overflow;
    logic       underflow;
    logic       div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, overflow, underflow, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, overflow, underflow, div_by_zero
    );
endinterface

// File: rtl/fp_divider.sv
// Sequential floating-point divider q = a / b using restoring mantissa division.
// Fixed latency: one quotient bit per clock, then a normalise/classify cycle.
module fp_divider #(
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 4,
    parameter int BIAS   = 3
) (
    input  logic            clk,
    input  logic            rst,
    fp_divider_if.slave     bus,
    output logic [2:0]      o_dbg_state
);
    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int M_W   = FRAC_W + 1;
    localparam int Q_W   = FRAC_W + 2;
    localparam int R_W   = M_W + 1;
    localparam int E_W   = EXP_W + 3;
    localparam int CNT_W = $clog2(Q_W);
    localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_NORM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state, w_next;
    logic [W-1:0]       r_a, r_b;
    logic               r_sign, r_a_zero, r_b_zero;
    logic [EXP_W-1:0]   r_ea, r_eb;
    logic [M_W-1:0]     r_mb;
    logic [R_W-1:0]     r_rem;
    logic [Q_W-1:0]     r_quo;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_q;
    logic               r_ovf, r_unf, r_dz;

    logic               w_busy, w_done;
    logic               w_ge;
    logic [R_W-1:0]     w_rem_sub;
    logic signed [E_W-1:0] w_e, w_exp;
    logic [FRAC_W-1:0]  w_frac;
    logic [W-1:0]       w_q;
    logic               w_ovf, w_unf, w_dz;

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_LOAD;
            S_LOAD: begin
                w_busy = 1'b1;
                w_next = S_DIV;
            end
            S_DIV: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(Q_W - 1)) w_next = S_NORM;
            end
            S_NORM: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // One restoring step: the remainder never exceeds twice the divisor, so R_W bits suffice.
    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_mb});
        w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    end

    always_comb begin
        w_e = $signed({{(E_W-EXP_W){1'b0}}, r_ea}) - $signed({{(E_W-EXP_W){1'b0}}, r_eb})
              + $signed(E_W'(BIAS));
        if (r_quo[Q_W-1]) begin
            w_frac = r_quo[Q_W-2:1];
            w_exp  = w_e;
        end else begin
            w_frac = r_quo[FRAC_W-1:0];
            w_exp  = w_e - E_W'(1);
        end
        w_q   = {r_sign, w_exp[EXP_W-1:0], w_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_dz  = 1'b0;
        if (r_b_zero) begin
            w_q  = {r_sign, {(W-1){1'b1}}};
            w_dz = 1'b1;
        end else if (r_a_zero) begin
            w_q = {r_sign, {(W-1){1'b0}}};
        end else if (w_exp > EXP_MAX) begin
            w_q   = {r_sign, {(W-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (w_exp < $signed(E_W'(1))) begin
            w_q   = {r_sign, {(W-1){1'b0}}};
            w_unf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_a_zero <= 1'b0;
            r_b_zero <= 1'b0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_mb     <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_a <= bus.a;
                    r_b <= bus.b;
                end
                S_LOAD: begin
                    r_sign   <= r_a[W-1] ^ r_b[W-1];
                    r_ea     <= r_a[W-2:FRAC_W];
                    r_eb     <= r_b[W-2:FRAC_W];
                    r_a_zero <= (r_a[W-2:FRAC_W] == '0);
                    r_b_zero <= (r_b[W-2:FRAC_W] == '0);
                    r_mb     <= {1'b1, r_b[FRAC_W-1:0]};
                    r_rem    <= {1'b0, 1'b1, r_a[FRAC_W-1:0]};
                    r_quo    <= '0;
                    r_cnt    <= '0;
                end
                S_DIV: begin
                    r_rem <= {w_rem_sub[R_W-2:0], 1'b0};
                    r_quo <= {r_quo[Q_W-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                // Results are loaded here so they are visible exactly while done is high.
                S_NORM: begin
                    r_q   <= w_q;
                    r_ovf <= w_ovf;
                    r_unf <= w_unf;
                    r_dz  <= w_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.q           = r_q;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;
    assign bus.div_by_zero = r_dz;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vector table, corner sequences,
// and randomized operands against an arithmetic reference model.
module tb_fp_divider;
  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         total;
  int         bad;

  fp_divider_if bus ();

  fp_divider dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [2:0] f;  // {overflow, underflow, div_by_zero}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: real quotient of the mantissas scaled by 32, truncated, then exponent rules.
  function automatic void ref_div(input logic [7:0] fa, input logic [7:0] fb,
                                  output logic [7:0] rq, output logic [2:0] rf);
    int  ea, eb, ma, mb, qq, e, fr;
    logic s;
    s  = fa[7] ^ fb[7];
    ea = int'(fa[6:4]);
    eb = int'(fb[6:4]);
    rf = 3'b000;
    rq = {s, 7'h00};
    if (eb == 0) begin
      rq = {s, 7'h7f};
      rf = 3'b001;
    end else if (ea != 0) begin
      ma = 16 + int'(fa[3:0]);
      mb = 16 + int'(fb[3:0]);
      qq = (ma * 32) / mb;
      e  = ea - eb + 3;
      if (qq >= 32) fr = (qq / 2) % 16;
      else begin
        fr = qq % 16;
        e  = e - 1;
      end
      if (e > 7) begin
        rq = {s, 7'h7f};
        rf = 3'b100;
      end else if (e < 1) begin
        rq = {s, 7'h00};
        rf = 3'b010;
      end else begin
        rq = {s, 3'(e), 4'(fr)};
      end
    end
  endfunction

  // Issue one operation from IDLE and wait (bounded) for done; lat is the done cycle, -1 on timeout.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       output logic [7:0] oq, output logic [2:0] of, output int lat);
    int busy_bad;
    busy_bad = 0;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = ia;
    bus.b = ib;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.done) begin
        lat = k;
        if (bus.busy) busy_bad++;
        break;
      end
      if (!bus.busy) busy_bad++;
      @(posedge clk);
      #1;
    end
    oq = bus.q;
    of = {bus.overflow, bus.underflow, bus.div_by_zero};
    check("busy_window", busy_bad, 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 0);
  endtask

  logic [7:0] got_q, exp_q;
  logic [2:0] got_f, exp_f;
  int         lat;
  int         n_done;
  int         done_cyc;
  logic [7:0] seq_q;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{8'h70, 8'h50, 8'h50, 3'b000};
    vecs[1] = '{8'h50, 8'h70, 8'h10, 3'b000};
    vecs[2] = '{8'hB0, 8'h38, 8'hA5, 3'b000};
    vecs[3] = '{8'h70, 8'h18, 8'h7F, 3'b100};
    vecs[4] = '{8'h10, 8'h70, 8'h00, 3'b010};
    vecs[5] = '{8'h50, 8'h00, 8'h7F, 3'b001};
    vecs[6] = '{8'h50, 8'h80, 8'hFF, 3'b001};
    vecs[7] = '{8'h00, 8'h50, 8'h00, 3'b000};
    vecs[8] = '{8'h00, 8'h00, 8'h7F, 3'b001};
    vecs[9] = '{8'h80, 8'h50, 8'h80, 3'b000};

    // Clock/reset
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 0);
    check("reset_done", {31'd0, bus.done}, 0);
    check("reset_q", {24'd0, bus.q}, 0);
    check("reset_flags", {29'd0, bus.overflow, bus.underflow, bus.div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, got_q, got_f, lat);
      check($sformatf("vec%0d_q", i), {24'd0, got_q}, {24'd0, vecs[i].q});
      check($sformatf("vec%0d_flags", i), {29'd0, got_f}, {29'd0, vecs[i].f});
      check($sformatf("vec%0d_latency", i), lat, 9);
    end

    // Extra start pulses during an operation must be ignored
    n_done = 0;
    done_cyc = -1;
    seq_q = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h70;
    bus.b = 8'h50;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.done) begin
        n_done++;
        done_cyc = k;
        seq_q = bus.q;
      end
      bus.start = (k == 3 || k == 5);
      if (bus.start) begin
        bus.a = 8'h10;
        bus.b = 8'h70;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check("ignore_start_ndone", n_done, 1);
    check("ignore_start_cycle", done_cyc, 9);
    check("ignore_start_q", {24'd0, seq_q}, 32'h50);

    // Reset in the middle of an operation aborts it
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h50;
    bus.b = 8'h70;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_done", {31'd0, bus.done}, 0);
    check("abort_q", {24'd0, bus.q}, 0);
    check("abort_flags", {29'd0, bus.overflow, bus.underflow, bus.div_by_zero}, 0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    do_op(8'hB0, 8'h38, got_q, got_f, lat);
    check("after_abort_q", {24'd0, got_q}, 32'hA5);
    check("after_abort_latency", lat, 9);

    // Randomized operands against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ref_div(ra, rb, exp_q, exp_f);
      do_op(ra, rb, got_q, got_f, lat);
      check($sformatf("rand_%02h_%02h_q", ra, rb), {24'd0, got_q}, {24'd0, exp_q});
      check($sformatf("rand_%02h_%02h_flags", ra, rb), {29'd0, got_f}, {29'd0, exp_f});
      check("rand_latency", lat, 9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
